// File: rtl/riscv_dm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_dm_pkg
// Description : Shared DMI widths, the failed-operation response code and the
//               state encoding of the DMI request arbiter. The ERR and DRAIN
//               states exist only when DMI_ARB_TIMEOUT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_dm_pkg;

  localparam int DMI_ADDR_WIDTH = 7;
  localparam int DMI_DATA_WIDTH = 32;
  localparam int DMI_OP_WIDTH   = 2;

  localparam logic [DMI_OP_WIDTH-1:0] DMI_OP_FAILED = 2'd2;

`ifdef DMI_ARB_TIMEOUT_EN
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FWD   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_ERR   = 3'd3,
    ST_DRAIN = 3'd4
  } dmi_arb_state_e;
`else
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FWD   = 3'd1,
    ST_WAIT  = 3'd2
  } dmi_arb_state_e;
`endif

  // Width of a requester index; never narrower than one bit.
  function automatic int dmi_arb_idx_w(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmi_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmi_rr_arbiter
// Description : Combinational round-robin selector. Searches the request
//               vector starting at (last_grant + 1) mod NUM_REQ and returns
//               the first requester found, plus an any-request flag.
// Ports       : i_req        - request vector
//               i_last_grant - index of the requester served last
//               o_grant      - selected requester (0 when nothing requests)
//               o_any_valid  - at least one request present
// Revision    : 1.0 - initial release
// ============================================================================
module dmi_rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_last_grant,
  output logic [IDX_W-1:0]   o_grant,
  output logic               o_any_valid
);

  logic [IDX_W-1:0] w_cand;

  // Walk the offsets from farthest to nearest so the nearest requester
  // after last_grant is the one left standing in o_grant.
  always_comb begin
    o_grant     = '0;
    o_any_valid = |i_req;
    w_cand      = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      w_cand = IDX_W'((int'(i_last_grant) + i) % NUM_REQ);
      if (i_req[w_cand]) begin
        o_grant = w_cand;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/dmi_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmi_req_arbiter
// Description : Shares one Debug Module DMI port between NUM_REQ requesters.
//               One transaction is outstanding at a time; requesters are
//               granted round-robin and the DM response is routed back to
//               the granted requester only.
//               Optional feature macro: DMI_ARB_TIMEOUT_EN - adds a response
//               timeout of TIMEOUT_CYCLES. On expiry the requester receives a
//               failed response and the late DM response is discarded.
// Ports       : clk_i, rstn_i                  - clock, async active-low reset
//               s_req_*  / s_resp_*            - requester-side channels
//               m_req_*  / m_resp_*            - DM-side channels
// Revision    : 1.0 - initial release
// ============================================================================
module dmi_req_arbiter
  import riscv_dm_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                                     clk_i,
  input  logic                                     rstn_i,
  // requester request channel
  input  logic [NUM_REQ-1:0]                       s_req_valid_i,
  output logic [NUM_REQ-1:0]                       s_req_ready_o,
  input  logic [NUM_REQ-1:0][DMI_ADDR_WIDTH-1:0]   s_req_addr_i,
  input  logic [NUM_REQ-1:0][DMI_DATA_WIDTH-1:0]   s_req_data_i,
  input  logic [NUM_REQ-1:0][DMI_OP_WIDTH-1:0]     s_req_op_i,
  // requester response channel
  output logic [NUM_REQ-1:0]                       s_resp_valid_o,
  input  logic [NUM_REQ-1:0]                       s_resp_ready_i,
  output logic [DMI_DATA_WIDTH-1:0]                s_resp_data_o,
  output logic [DMI_OP_WIDTH-1:0]                  s_resp_op_o,
  // DM request channel
  output logic                                     m_req_valid_o,
  input  logic                                     m_req_ready_i,
  output logic [DMI_ADDR_WIDTH-1:0]                m_req_addr_o,
  output logic [DMI_DATA_WIDTH-1:0]                m_req_data_o,
  output logic [DMI_OP_WIDTH-1:0]                  m_req_op_o,
  // DM response channel
  input  logic                                     m_resp_valid_i,
  output logic                                     m_resp_ready_o,
  input  logic [DMI_DATA_WIDTH-1:0]                m_resp_data_i,
  input  logic [DMI_OP_WIDTH-1:0]                  m_resp_op_i
);

  localparam int IDX_W = dmi_arb_idx_w(NUM_REQ);
  localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(NUM_REQ - 1);

  dmi_arb_state_e             r_state;
  logic [IDX_W-1:0]           r_grant;
  logic [IDX_W-1:0]           r_last_grant;
  logic                       r_m_req_valid;
  logic [DMI_ADDR_WIDTH-1:0]  r_m_req_addr;
  logic [DMI_DATA_WIDTH-1:0]  r_m_req_data;
  logic [DMI_OP_WIDTH-1:0]    r_m_req_op;

  logic [IDX_W-1:0]           w_rr_grant;
  logic                       w_any_valid;
  logic                       w_resp_hs;

`ifdef DMI_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] r_timeout_cnt;
`else
  logic w_unused_timeout_cfg;
  assign w_unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
`endif

  dmi_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .i_req        (s_req_valid_i),
    .i_last_grant (r_last_grant),
    .o_grant      (w_rr_grant),
    .o_any_valid  (w_any_valid)
  );

  // Response handshake between the DM and the granted requester.
  assign w_resp_hs = m_resp_valid_i && s_resp_ready_i[r_grant];

  // --------------------------------------------------------------------------
  // Control FSM. The DM request valid and payload are registered when the
  // grant is taken, so the granted requester's payload is presented to the
  // DM one cycle after its valid is seen in IDLE.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state       <= ST_IDLE;
      r_grant       <= '0;
      r_last_grant  <= c_last_idx;
      r_m_req_valid <= 1'b0;
      r_m_req_addr  <= '0;
      r_m_req_data  <= '0;
      r_m_req_op    <= '0;
`ifdef DMI_ARB_TIMEOUT_EN
      r_timeout_cnt <= '0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any_valid) begin
            r_grant       <= w_rr_grant;
            r_m_req_valid <= 1'b1;
            r_m_req_addr  <= s_req_addr_i[w_rr_grant];
            r_m_req_data  <= s_req_data_i[w_rr_grant];
            r_m_req_op    <= s_req_op_i[w_rr_grant];
            r_state       <= ST_FWD;
          end
        end

        // The grant is held even if the requester drops valid here.
        ST_FWD: begin
          if (m_req_ready_i) begin
            r_m_req_valid <= 1'b0;
            r_state       <= ST_WAIT;
`ifdef DMI_ARB_TIMEOUT_EN
            r_timeout_cnt <= '0;
`endif
          end
        end

        ST_WAIT: begin
          if (w_resp_hs) begin
            r_last_grant <= r_grant;
            r_state      <= ST_IDLE;
          end
`ifdef DMI_ARB_TIMEOUT_EN
          // A DM response present in the expiry cycle wins over the timeout;
          // the counter only advances while the DM is silent.
          else if (!m_resp_valid_i) begin
            if (r_timeout_cnt == c_cnt_last) begin
              r_state <= ST_ERR;
            end else begin
              r_timeout_cnt <= r_timeout_cnt + 1'b1;
            end
          end
`endif
        end

`ifdef DMI_ARB_TIMEOUT_EN
        ST_ERR: begin
          if (s_resp_ready_i[r_grant]) begin
            r_state <= ST_DRAIN;
          end
        end

        // Swallow the one late DM response before accepting new work.
        ST_DRAIN: begin
          if (m_resp_valid_i) begin
            r_last_grant <= r_grant;
            r_state      <= ST_IDLE;
          end
        end
`endif

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign m_req_valid_o = r_m_req_valid;
  assign m_req_addr_o  = r_m_req_addr;
  assign m_req_data_o  = r_m_req_data;
  assign m_req_op_o    = r_m_req_op;

  // --------------------------------------------------------------------------
  // Handshake routing. Everything is gated by state, so an asynchronous
  // reset (which forces IDLE) clears all of these outputs immediately.
  // --------------------------------------------------------------------------
  always_comb begin
    s_req_ready_o  = '0;
    s_resp_valid_o = '0;
    s_resp_data_o  = '0;
    s_resp_op_o    = '0;
    m_resp_ready_o = 1'b0;
    case (r_state)
      ST_FWD: begin
        s_req_ready_o[r_grant] = m_req_ready_i;
      end
      ST_WAIT: begin
        s_resp_valid_o[r_grant] = m_resp_valid_i;
        s_resp_data_o           = m_resp_data_i;
        s_resp_op_o             = m_resp_op_i;
        m_resp_ready_o          = s_resp_ready_i[r_grant];
      end
`ifdef DMI_ARB_TIMEOUT_EN
      ST_ERR: begin
        s_resp_valid_o[r_grant] = 1'b1;
        s_resp_op_o             = DMI_OP_FAILED;
      end
      ST_DRAIN: begin
        m_resp_ready_o = 1'b1;
      end
`endif
      default: begin
        m_resp_ready_o = 1'b0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_dmi_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmi_req_arbiter
// Description : Directed self-checking bench for dmi_req_arbiter with two
//               requesters. The timeout scenario is built only when
//               DMI_ARB_TIMEOUT_EN is defined (TIMEOUT_CYCLES = 8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmi_req_arbiter;
  import riscv_dm_pkg::*;

  localparam int NUM_REQ = 2;

  logic                                   clk_i = 1'b0;
  logic                                   rstn_i;
  logic [NUM_REQ-1:0]                     s_req_valid_i;
  logic [NUM_REQ-1:0]                     s_req_ready_o;
  logic [NUM_REQ-1:0][DMI_ADDR_WIDTH-1:0] s_req_addr_i;
  logic [NUM_REQ-1:0][DMI_DATA_WIDTH-1:0] s_req_data_i;
  logic [NUM_REQ-1:0][DMI_OP_WIDTH-1:0]   s_req_op_i;
  logic [NUM_REQ-1:0]                     s_resp_valid_o;
  logic [NUM_REQ-1:0]                     s_resp_ready_i;
  logic [DMI_DATA_WIDTH-1:0]              s_resp_data_o;
  logic [DMI_OP_WIDTH-1:0]                s_resp_op_o;
  logic                                   m_req_valid_o;
  logic                                   m_req_ready_i;
  logic [DMI_ADDR_WIDTH-1:0]              m_req_addr_o;
  logic [DMI_DATA_WIDTH-1:0]              m_req_data_o;
  logic [DMI_OP_WIDTH-1:0]                m_req_op_o;
  logic                                   m_resp_valid_i;
  logic                                   m_resp_ready_o;
  logic [DMI_DATA_WIDTH-1:0]              m_resp_data_i;
  logic [DMI_OP_WIDTH-1:0]                m_resp_op_i;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk_i = ~clk_i;

  dmi_req_arbiter #(
    .NUM_REQ        (NUM_REQ),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk_i          (clk_i),
    .rstn_i         (rstn_i),
    .s_req_valid_i  (s_req_valid_i),
    .s_req_ready_o  (s_req_ready_o),
    .s_req_addr_i   (s_req_addr_i),
    .s_req_data_i   (s_req_data_i),
    .s_req_op_i     (s_req_op_i),
    .s_resp_valid_o (s_resp_valid_o),
    .s_resp_ready_i (s_resp_ready_i),
    .s_resp_data_o  (s_resp_data_o),
    .s_resp_op_o    (s_resp_op_o),
    .m_req_valid_o  (m_req_valid_o),
    .m_req_ready_i  (m_req_ready_i),
    .m_req_addr_o   (m_req_addr_o),
    .m_req_data_o   (m_req_data_o),
    .m_req_op_o     (m_req_op_o),
    .m_resp_valid_i (m_resp_valid_i),
    .m_resp_ready_o (m_resp_ready_o),
    .m_resp_data_i  (m_resp_data_i),
    .m_resp_op_i    (m_resp_op_i)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Step to just after the next rising edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, ".m_req_valid"},  32'(m_req_valid_o),  32'h0);
    chk({tag, ".s_req_ready"},  32'(s_req_ready_o),  32'h0);
    chk({tag, ".s_resp_valid"}, 32'(s_resp_valid_o), 32'h0);
    chk({tag, ".m_resp_ready"}, 32'(m_resp_ready_o), 32'h0);
    chk({tag, ".m_req_addr"},   32'(m_req_addr_o),   32'h0);
    chk({tag, ".m_req_data"},   m_req_data_o,        32'h0);
    chk({tag, ".m_req_op"},     32'(m_req_op_o),     32'h0);
    chk({tag, ".s_resp_data"},  s_resp_data_o,       32'h0);
  endtask

  // Complete transaction for a single requester, starting in IDLE.
  task automatic txn(input string tag, input int idx, input logic [6:0] a,
                     input logic [31:0] d, input logic [1:0] op,
                     input logic [31:0] rd, input logic [1:0] rop);
    s_req_valid_i       = '0;
    s_req_valid_i[idx]  = 1'b1;
    s_req_addr_i[idx]   = a;
    s_req_data_i[idx]   = d;
    s_req_op_i[idx]     = op;
    #1;
    chk({tag, ".idle_mvalid"}, 32'(m_req_valid_o), 32'h0);
    tick();
    chk({tag, ".mvalid"}, 32'(m_req_valid_o), 32'h1);
    chk({tag, ".addr"},   32'(m_req_addr_o),  32'(a));
    chk({tag, ".data"},   m_req_data_o,       d);
    chk({tag, ".op"},     32'(m_req_op_o),    32'(op));
    chk({tag, ".sready_nomready"}, 32'(s_req_ready_o), 32'h0);
    m_req_ready_i = 1'b1;
    #1;
    chk({tag, ".sready"}, 32'(s_req_ready_o), 32'(1) << idx);
    tick();
    s_req_valid_i  = '0;
    m_req_ready_i  = 1'b0;
    m_resp_valid_i = 1'b1;
    m_resp_data_i  = rd;
    m_resp_op_i    = rop;
    s_resp_ready_i = '1;
    #1;
    chk({tag, ".wait_mvalid"}, 32'(m_req_valid_o),  32'h0);
    chk({tag, ".resp_valid"},  32'(s_resp_valid_o), 32'(1) << idx);
    chk({tag, ".resp_data"},   s_resp_data_o,       rd);
    chk({tag, ".resp_op"},     32'(s_resp_op_o),    32'(rop));
    chk({tag, ".mresp_ready"}, 32'(m_resp_ready_o), 32'h1);
    tick();
    m_resp_valid_i = 1'b0;
    s_resp_ready_i = '0;
    #1;
    chk({tag, ".done_resp_valid"}, 32'(s_resp_valid_o), 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn_i         = 1'b0;
    s_req_valid_i  = '0;
    s_req_addr_i   = '0;
    s_req_data_i   = '0;
    s_req_op_i     = '0;
    s_resp_ready_i = '0;
    m_req_ready_i  = 1'b0;
    m_resp_valid_i = 1'b0;
    m_resp_data_i  = '0;
    m_resp_op_i    = '0;
    #12;
    chk_quiet("reset");
    tick();
    rstn_i = 1'b1;

    // Single requester 0: request forwarded next cycle, response only to 0.
    txn("single0", 0, 7'h10, 32'h1, 2'd2, 32'h0000_ABCD, 2'd0);

    // Fresh reset, then both requesters valid together: 0 first, then 1.
    rstn_i = 1'b0;
    #1;
    chk_quiet("reset2");
    tick();
    rstn_i          = 1'b1;
    s_req_valid_i   = 2'b11;
    s_req_addr_i[0] = 7'h11;  s_req_data_i[0] = 32'hA0;  s_req_op_i[0] = 2'd1;
    s_req_addr_i[1] = 7'h22;  s_req_data_i[1] = 32'hB1;  s_req_op_i[1] = 2'd1;
    tick();
    chk("both.first_addr", 32'(m_req_addr_o), 32'h11);
    chk("both.first_data", m_req_data_o, 32'hA0);
    m_req_ready_i = 1'b1;
    #1;
    chk("both.first_sready", 32'(s_req_ready_o), 32'h1);
    tick();
    s_req_valid_i  = 2'b10;
    m_req_ready_i  = 1'b0;
    m_resp_valid_i = 1'b1;
    m_resp_data_i  = 32'h1111;
    s_resp_ready_i = 2'b11;
    #1;
    chk("both.wait_sready", 32'(s_req_ready_o), 32'h0);
    chk("both.first_resp_valid", 32'(s_resp_valid_o), 32'h1);
    tick();
    m_resp_valid_i = 1'b0;
    #1;
    chk("both.idle_mvalid", 32'(m_req_valid_o), 32'h0);
    tick();
    chk("both.second_addr", 32'(m_req_addr_o), 32'h22);
    chk("both.second_data", m_req_data_o, 32'hB1);
    m_req_ready_i = 1'b1;
    #1;
    chk("both.second_sready", 32'(s_req_ready_o), 32'h2);
    tick();

    // Requester 1 stalls its response for 5 cycles while 0 requests again.
    s_req_valid_i   = 2'b01;
    s_req_addr_i[0] = 7'h33;
    s_resp_ready_i  = 2'b01;
    m_resp_valid_i  = 1'b1;
    m_resp_data_i   = 32'h2222;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("stall%0d.mresp_ready", i), 32'(m_resp_ready_o), 32'h0);
      chk($sformatf("stall%0d.resp_valid", i),  32'(s_resp_valid_o), 32'h2);
      chk($sformatf("stall%0d.mvalid", i),      32'(m_req_valid_o),  32'h0);
      tick();
    end
    s_resp_ready_i = 2'b11;
    #1;
    chk("stall.release_mresp_ready", 32'(m_resp_ready_o), 32'h1);
    chk("stall.release_data", s_resp_data_o, 32'h2222);
    tick();
    m_resp_valid_i = 1'b0;
    #1;
    chk("stall.idle_mvalid", 32'(m_req_valid_o), 32'h0);
    tick();
    chk("after_stall.addr", 32'(m_req_addr_o), 32'h33);
    tick();
    s_req_valid_i  = '0;
    m_req_ready_i  = 1'b0;
    m_resp_valid_i = 1'b1;
    tick();
    m_resp_valid_i = 1'b0;

    // Requester 1 in flight (last grant = 0) when reset hits in WAIT.
    s_req_valid_i   = 2'b10;
    s_req_addr_i[1] = 7'h44;
    tick();
    chk("rstwait.fwd_addr", 32'(m_req_addr_o), 32'h44);
    m_req_ready_i = 1'b1;
    tick();
    s_req_valid_i = '0;
    m_req_ready_i = 1'b0;
    #1;
    chk("rstwait.mresp_ready", 32'(m_resp_ready_o), 32'h1);
    rstn_i = 1'b0;
    #1;
    chk_quiet("rstwait.async");
    tick();
    rstn_i          = 1'b1;
    s_resp_ready_i  = '0;
    s_req_valid_i   = 2'b11;
    s_req_addr_i[0] = 7'h55;
    s_req_addr_i[1] = 7'h66;
    #1;
    chk("rstwait.idle_mvalid", 32'(m_req_valid_o), 32'h0);
    tick();
    chk("rstwait.regrant_addr", 32'(m_req_addr_o), 32'h55);
    m_req_ready_i = 1'b1;
    #1;
    chk("rstwait.regrant_sready", 32'(s_req_ready_o), 32'h1);
    tick();
    s_req_valid_i  = '0;
    m_req_ready_i  = 1'b0;
    m_resp_valid_i = 1'b1;
    s_resp_ready_i = '1;
    tick();
    m_resp_valid_i = 1'b0;
    s_resp_ready_i = '0;

`ifdef DMI_ARB_TIMEOUT_EN
    // Silent DM: failed response after 8 WAIT cycles, late response dropped.
    txn("pre_to", 1, 7'h07, 32'h7, 2'd1, 32'h7777, 2'd0);
    s_req_valid_i   = 2'b01;
    s_req_addr_i[0] = 7'h12;
    tick();
    m_req_ready_i = 1'b1;
    tick();
    s_req_valid_i = '0;
    m_req_ready_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk($sformatf("to_wait%0d.resp_valid", i), 32'(s_resp_valid_o), 32'h0);
      tick();
    end
    s_resp_ready_i = 2'b01;
    #1;
    chk("to.err_valid",       32'(s_resp_valid_o), 32'h1);
    chk("to.err_data",        s_resp_data_o,       32'h0);
    chk("to.err_op",          32'(s_resp_op_o),    32'h2);
    chk("to.err_mresp_ready", 32'(m_resp_ready_o), 32'h0);
    tick();
    s_resp_ready_i = '0;
    m_resp_valid_i = 1'b1;
    m_resp_data_i  = 32'hDEAD;
    #1;
    chk("to.drain_resp_valid",  32'(s_resp_valid_o), 32'h0);
    chk("to.drain_mresp_ready", 32'(m_resp_ready_o), 32'h1);
    chk("to.drain_data",        s_resp_data_o,       32'h0);
    tick();
    m_resp_valid_i = 1'b0;
    #1;
    chk("to.idle_mresp_ready", 32'(m_resp_ready_o), 32'h0);
`endif

    // Normal transaction for requester 1 to close out.
    txn("final1", 1, 7'h3F, 32'hCAFE_0001, 2'd1, 32'h1234_5678, 2'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
